cdb_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cdb_req_fifo.sv | 48 ++++
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ROB tag / result widths, idle CDB tag, functional-unit opcodes
// and the round-robin index helper used by the CDB arbiter.
package cpu_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [ROB_W-1:0] INVALID_TAG = 6'b010000;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_LOAD   = 4'd4;
  localparam logic [3:0] OP_STORE  = 4'd5;
  localparam logic [3:0] OP_BRANCH = 4'd6;

  function automatic int rr_idx(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    while (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Two-entry per-requester result queue with push/pop/flush and occupancy count.
module cdb_req_fifo
  import cpu_pkg::*;
#(
  parameter int TAG_W = ROB_W,
  parameter int DAT_W = DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] push_tag,
  input  logic [DAT_W-1:0] push_data,
  output logic [TAG_W-1:0] head_tag,
  output logic [DAT_W-1:0] head_data,
  output logic [1:0]       count
);

  logic [TAG_W+DAT_W-1:0] mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // A push while full is silently dropped; flush overrides both operations.
  assign do_push = push && (count < 2'd2) && !flush;
  assign do_pop  = pop && (count != 2'd0) && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= {push_tag, push_data};
  end

  assign {head_tag, head_data} = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving two registered CDB lanes from NUM_REQ result queues.
// Optional statistics counters are enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ROB_W   = cpu_pkg::ROB_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter logic [ROB_W-1:0] INVALID_TAG = cpu_pkg::INVALID_TAG
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_robNum,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]               stat_bcast_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ROB_W-1:0]   head_tag  [NUM_REQ];
  logic [DATA_W-1:0]  head_data [NUM_REQ];
  logic [1:0]         count     [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] pop;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   g1_idx;
  logic [PTR_W-1:0]   g2_idx;
  logic               g1_found;
  logic               g2_found;
  logic               gnt1;
  logic               gnt2;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
      cdb_req_fifo #(
        .TAG_W (ROB_W),
        .DAT_W (DATA_W)
      ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (req_valid[k]),
        .pop       (pop[k]),
        .push_tag  (req_robNum[k*ROB_W +: ROB_W]),
        .push_data (req_data[k*DATA_W +: DATA_W]),
        .head_tag  (head_tag[k]),
        .head_data (head_data[k]),
        .count     (count[k])
      );
      assign req_ready[k] = (count[k] < 2'd2);
      assign nonempty[k]  = (count[k] != 2'd0);
    end
  endgenerate

  // Scan from the pointer; the first two distinct non-empty queues win the lanes.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'(rr_idx(int'(ptr), i, NUM_REQ));
      if (nonempty[scan_idx]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end else if (!g2_found) begin
          g2_found = 1'b1;
          g2_idx   = scan_idx;
        end
      end
    end
  end

  assign gnt1 = g1_found && !flush;
  assign gnt2 = g2_found && !flush;

  always_comb begin
    pop     = '0;
    ptr_nxt = ptr;
    if (gnt1) begin
      pop[g1_idx] = 1'b1;
      ptr_nxt     = PTR_W'(rr_idx(int'(g1_idx), 1, NUM_REQ));
    end
    if (gnt2) begin
      pop[g2_idx] = 1'b1;
      ptr_nxt     = PTR_W'(rr_idx(int'(g2_idx), 1, NUM_REQ));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

  // Idle lanes keep their last data so consumers see no needless toggling.
  always_ff @(posedge clock) begin
    if (reset) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_TAG;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_TAG;
      CDBdata2   <= '0;
    end else begin
      CDBiscast  <= gnt1;
      CDBrobNum  <= gnt1 ? head_tag[g1_idx] : INVALID_TAG;
      if (gnt1) CDBdata <= head_data[g1_idx];
      CDBiscast2 <= gnt2;
      CDBrobNum2 <= gnt2 ? head_tag[g2_idx] : INVALID_TAG;
      if (gnt2) CDBdata2 <= head_data[g2_idx];
    end
  end

`ifdef CDB_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_bcast_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if ((CDBiscast || CDBiscast2) && (stat_bcast_cnt != '1))
        stat_bcast_cnt <= stat_bcast_cnt + 32'd1;
      if ((|(req_valid & ~req_ready)) && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model, per-cycle expectations.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int RW = 6;
  localparam int DW = 32;
  localparam logic [RW-1:0] INV = 6'd16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_robNum = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            CDBiscast, CDBiscast2;
  logic [RW-1:0]   CDBrobNum, CDBrobNum2;
  logic [DW-1:0]   CDBdata, CDBdata2;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]     stat_bcast_cnt, stat_stall_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .ROB_W(RW), .DATA_W(DW), .INVALID_TAG(INV)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_robNum (req_robNum),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .CDBiscast  (CDBiscast),
    .CDBrobNum  (CDBrobNum),
    .CDBdata    (CDBdata),
    .CDBiscast2 (CDBiscast2),
    .CDBrobNum2 (CDBrobNum2),
    .CDBdata2   (CDBdata2)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_bcast_cnt (stat_bcast_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          v1;
    logic [RW-1:0] t1;
    logic [DW-1:0] d1;
    logic          v2;
    logic [RW-1:0] t2;
    logic [DW-1:0] d2;
    logic [N-1:0]  rdy;
    int unsigned   bc;
    int unsigned   st;
  } exp_t;

  exp_t exp_q[$];
  logic [RW+DW-1:0] mq [N][$];

  int          errors = 0;
  int          checks = 0;
  int          m_ptr  = 0;
  logic        m_v1 = 1'b0, m_v2 = 1'b0;
  logic [DW-1:0] m_d1 = '0, m_d2 = '0;
  int unsigned m_bc = 0, m_st = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Reference model: one call = effect of the coming rising edge.
  task automatic model_step(input bit rst, input bit fl, input logic [N-1:0] v,
                            input logic [N*RW-1:0] tg, input logic [N*DW-1:0] dt);
    logic [N-1:0]     rdy0;
    int               g[$];
    logic [RW+DW-1:0] h;
    exp_t             e;
    for (int k = 0; k < N; k++) rdy0[k] = (mq[k].size() < 2);
    e.t1 = INV;
    e.t2 = INV;
    if (rst) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_ptr = 0; m_v1 = 0; m_v2 = 0; m_d1 = '0; m_d2 = '0; m_bc = 0; m_st = 0;
    end else begin
      if ((m_v1 || m_v2) && m_bc != 32'hFFFF_FFFF) m_bc++;
      if ((|(v & ~rdy0)) && m_st != 32'hFFFF_FFFF) m_st++;
      if (fl) begin
        for (int k = 0; k < N; k++) mq[k].delete();
        m_v1 = 0; m_v2 = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (mq[k].size() > 0 && g.size() < 2) g.push_back(k);
        end
        m_v1 = (g.size() > 0);
        m_v2 = (g.size() > 1);
        if (m_v1) begin
          h = mq[g[0]].pop_front();
          e.t1 = h[RW+DW-1:DW];
          m_d1 = h[DW-1:0];
        end
        if (m_v2) begin
          h = mq[g[1]].pop_front();
          e.t2 = h[RW+DW-1:DW];
          m_d2 = h[DW-1:0];
        end
        if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % N;
        for (int k = 0; k < N; k++)
          if (v[k] && rdy0[k]) mq[k].push_back({tg[k*RW +: RW], dt[k*DW +: DW]});
      end
    end
    e.v1 = m_v1; e.d1 = m_d1;
    e.v2 = m_v2; e.d2 = m_d2;
    for (int k = 0; k < N; k++) e.rdy[k] = (mq[k].size() < 2);
    e.bc = m_bc;
    e.st = m_st;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit fl, input logic [N-1:0] v,
                     input logic [N*RW-1:0] tg, input logic [N*DW-1:0] dt);
    reset = rst; flush = fl; req_valid = v; req_robNum = tg; req_data = dt;
    model_step(rst, fl, v, tg, dt);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0);
  endtask

  // Monitor: each cycle the DUT presents lane state, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("lane1_valid", 64'(CDBiscast),  64'(e.v1));
        chk("lane1_tag",   64'(CDBrobNum),  64'(e.t1));
        chk("lane1_data",  64'(CDBdata),    64'(e.d1));
        chk("lane2_valid", 64'(CDBiscast2), 64'(e.v2));
        chk("lane2_tag",   64'(CDBrobNum2), 64'(e.t2));
        chk("lane2_data",  64'(CDBdata2),   64'(e.d2));
        chk("req_ready",   64'(req_ready),  64'(e.rdy));
`ifdef CDB_ARB_STATS_EN
        chk("stat_bcast",  64'(stat_bcast_cnt), 64'(e.bc));
        chk("stat_stall",  64'(stat_stall_cnt), 64'(e.st));
`endif
      end
    end
  end

  initial begin
    logic [N-1:0]    rv;
    logic [N*RW-1:0] rt;
    logic [N*DW-1:0] rd;
    int              w;

    cyc(1, 0, '0, '0, '0);
    cyc(1, 0, '0, '0, '0);
    idle(5);

    // Single result from requester 2.
    cyc(0, 0, 4'b0100, 24'(6'd5) << 12, 128'(32'h1234) << 64);
    idle(3);

    // All four push together from pointer 0.
    cyc(1, 0, '0, '0, '0);
    cyc(0, 0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
        {32'hD4, 32'hC3, 32'hB2, 32'hA1});
    idle(4);

    // Requester 0 alone, three back-to-back pushes.
    cyc(0, 0, 4'b0001, 24'd7, 128'h70);
    cyc(0, 0, 4'b0001, 24'd8, 128'h80);
    cyc(0, 0, 4'b0001, 24'd9, 128'h90);
    idle(4);

    // Fill queues, then flush together with a new push.
    cyc(0, 0, 4'b1111, {6'd14, 6'd13, 6'd12, 6'd11}, {4{32'h1111_0000}});
    cyc(0, 0, 4'b1111, {6'd24, 6'd23, 6'd22, 6'd21}, {4{32'h2222_0000}});
    cyc(0, 1, 4'b0010, 24'd30 << 6, 128'h3333 << 32);
    idle(4);

    // Sustained contention so queues fill and valid-while-full occurs.
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 4'b1111, 24'($urandom), {$urandom, $urandom, $urandom, $urandom});
    idle(4);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom) & 4'($urandom | $urandom);
      rt = 24'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0), rv, rt, rd);
    end
    idle(6);

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
